// File: rtl/el_tx_sync.sv
// el_tx_sync: turns words into return-to-spacer one-hot tokens paced by a synchronized ack.
module el_tx_sync #(
    parameter int RAIL_NUM = 2,
    parameter int WORD_SYMS = 4,
    parameter int TIMEOUT = 255,
    localparam int SYM_BITS = $clog2(RAIL_NUM),
    localparam int DATA_W = WORD_SYMS * SYM_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [DATA_W-1:0]   s_data,
    input  logic                ack_i,
    output logic [RAIL_NUM-1:0] out,
    output logic                busy,
    output logic                err
);
    localparam int CW = (WORD_SYMS > 1) ? $clog2(WORD_SYMS) : 1;
    localparam logic [CW-1:0] LAST = CW'(WORD_SYMS - 1);
    localparam logic [15:0] TO_M1 = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, DATA, SPACER, ERR} state_t;

    state_t              state;
    logic                ack_m, ack_s;
    logic [DATA_W-1:0]   sh;
    logic [DATA_W-1:0]   sh_nx;
    logic [CW-1:0]       cnt;
    logic [15:0]         tcnt;

    function automatic logic [RAIL_NUM-1:0] onehot(input logic [SYM_BITS-1:0] v);
        return {{(RAIL_NUM-1){1'b0}}, 1'b1} << v;
    endfunction

    assign sh_nx   = sh >> SYM_BITS;
    assign s_ready = state == IDLE;
    assign busy    = state != IDLE;
    assign err     = state == ERR;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            out   <= '0;
            ack_m <= 1'b0;
            ack_s <= 1'b0;
            sh    <= '0;
            cnt   <= '0;
            tcnt  <= '0;
        end else begin
            ack_m <= ack_i;
            ack_s <= ack_m;
            case (state)
                IDLE: if (s_valid) begin
                    sh    <= s_data;
                    cnt   <= '0;
                    tcnt  <= '0;
                    out   <= onehot(s_data[SYM_BITS-1:0]);
                    state <= DATA;
                end
                DATA: if (ack_s) begin
                    out   <= '0;
                    tcnt  <= '0;
                    state <= SPACER;
                end else if (tcnt == TO_M1) begin
                    out   <= '0;
                    state <= ERR;
                end else begin
                    tcnt <= tcnt + 16'd1;
                end
                SPACER: if (!ack_s) begin
                    tcnt <= '0;
                    if (cnt == LAST) begin
                        state <= IDLE;
                    end else begin
                        sh    <= sh_nx;
                        cnt   <= cnt + 1'b1;
                        out   <= onehot(sh_nx[SYM_BITS-1:0]);
                        state <= DATA;
                    end
                end else if (tcnt == TO_M1) begin
                    state <= ERR;
                end else begin
                    tcnt <= tcnt + 16'd1;
                end
                default: out <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_el_tx_sync.sv
// tb_el_tx_sync: scoreboard of expected rail sequences for two configurations plus corner sequences.
module tb_el_tx_sync;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       sv_a = 1'b0, sr_a, ack_a, busy_a, err_a;
    logic [3:0] sd_a = '0;
    logic [1:0] out_a;
    logic       sv_b = 1'b0, sr_b, ack_b, busy_b, err_b;
    logic [3:0] sd_b = '0;
    logic [3:0] out_b;

    logic [2:0] pa = '0, pb = '0;
    logic       fa_en = 1'b0, fa = 1'b0, fb_en = 1'b0, fb = 1'b0;
    always @(posedge clk) begin
        pa <= {pa[1:0], ^out_a};
        pb <= {pb[1:0], ^out_b};
    end
    assign ack_a = fa_en ? fa : pa[2];
    assign ack_b = fb_en ? fb : pb[2];

    el_tx_sync #(.RAIL_NUM(2), .WORD_SYMS(4), .TIMEOUT(8)) ua (
        .clk(clk), .rst(rst), .s_valid(sv_a), .s_ready(sr_a), .s_data(sd_a),
        .ack_i(ack_a), .out(out_a), .busy(busy_a), .err(err_a));
    el_tx_sync #(.RAIL_NUM(4), .WORD_SYMS(2)) ub (
        .clk(clk), .rst(rst), .s_valid(sv_b), .s_ready(sr_b), .s_data(sd_b),
        .ack_i(ack_b), .out(out_b), .busy(busy_b), .err(err_b));

    int checks = 0;
    int errors = 0;
    logic [1:0] qa[$];
    logic [3:0] qb[$];
    logic       mon_en = 1'b1;
    logic [1:0] prev_a = '0;
    logic [3:0] prev_b = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // every rail change must be the next expected token or spacer, never token->token
    always @(negedge clk) begin
        if (mon_en && out_a !== prev_a) begin
            if (prev_a != 0) chk("a_token_to_spacer", 32'(out_a), 0);
            if (qa.size() == 0) chk("a_unexpected_change", 32'(out_a), 32'(prev_a));
            else chk("a_out", 32'(out_a), 32'(qa.pop_front()));
        end
        prev_a = out_a;
    end
    always @(negedge clk) begin
        if (mon_en && out_b !== prev_b) begin
            if (prev_b != 0) chk("b_token_to_spacer", 32'(out_b), 0);
            if (qb.size() == 0) chk("b_unexpected_change", 32'(out_b), 32'(prev_b));
            else chk("b_out", 32'(out_b), 32'(qb.pop_front()));
        end
        prev_b = out_b;
    end

    typedef struct {
        logic [3:0] data;
        logic [7:0] toks;
    } vec_a_t;
    typedef struct {
        logic [3:0] data;
        logic [7:0] toks;
    } vec_b_t;

    task automatic push_a(input logic [7:0] t);
        for (int k = 0; k < 4; k++) begin
            qa.push_back(t[2*k +: 2]);
            qa.push_back(2'b00);
        end
    endtask

    task automatic push_b(input logic [7:0] t);
        for (int k = 0; k < 2; k++) begin
            qb.push_back(t[4*k +: 4]);
            qb.push_back(4'b0000);
        end
    endtask

    task automatic send_a(input logic [3:0] d, input logic [7:0] t);
        int n = 0;
        while (!sr_a && n < 300) begin @(negedge clk); n++; end
        chk("a_ready_wait", 32'(sr_a), 1);
        push_a(t);
        sd_a = d;
        sv_a = 1'b1;
        @(posedge clk);
        #1 sv_a = 1'b0;
        chk("a_busy_after_hs", 32'(busy_a), 1);
        chk("a_ready_after_hs", 32'(sr_a), 0);
    endtask

    task automatic send_b(input logic [3:0] d, input logic [7:0] t);
        int n = 0;
        while (!sr_b && n < 300) begin @(negedge clk); n++; end
        chk("b_ready_wait", 32'(sr_b), 1);
        push_b(t);
        sd_b = d;
        sv_b = 1'b1;
        @(posedge clk);
        #1 sv_b = 1'b0;
        chk("b_busy_after_hs", 32'(busy_b), 1);
        chk("b_ready_after_hs", 32'(sr_b), 0);
    endtask

    task automatic wait_idle_a;
        int n = 0;
        while (busy_a && n < 300) begin @(negedge clk); n++; end
        chk("a_idle_wait", 32'(busy_a), 0);
        chk("a_queue_drained", 32'(qa.size()), 0);
        chk("a_ready_idle", 32'(sr_a), 1);
        chk("a_err_idle", 32'(err_a), 0);
    endtask

    task automatic wait_idle_b;
        int n = 0;
        while (busy_b && n < 300) begin @(negedge clk); n++; end
        chk("b_idle_wait", 32'(busy_b), 0);
        chk("b_queue_drained", 32'(qb.size()), 0);
        chk("b_ready_idle", 32'(sr_b), 1);
        chk("b_err_idle", 32'(err_b), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        vec_a_t ta[5];
        vec_b_t tb[3];
        int n;
        ta[0] = '{4'b1010, 8'b10_01_10_01};
        ta[1] = '{4'b1111, 8'b10_10_10_10};
        ta[2] = '{4'b0000, 8'b01_01_01_01};
        ta[3] = '{4'b0110, 8'b01_10_10_01};
        ta[4] = '{4'b0001, 8'b01_01_01_10};
        tb[0] = '{4'b0111, 8'b0010_1000};
        tb[1] = '{4'b1100, 8'b1000_0001};
        tb[2] = '{4'b0110, 8'b0010_0100};

        #1 rst = 1'b1;
        #2;
        chk("rst_out_a", 32'(out_a), 0);
        chk("rst_busy_a", 32'(busy_a), 0);
        chk("rst_err_a", 32'(err_a), 0);
        chk("rst_out_b", 32'(out_b), 0);
        chk("rst_busy_b", 32'(busy_b), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ready_a", 32'(sr_a), 1);
        chk("rst_ready_b", 32'(sr_b), 1);

        for (int i = 0; i < 5; i++) begin
            send_a(ta[i].data, ta[i].toks);
            wait_idle_a();
        end
        for (int i = 0; i < 3; i++) begin
            send_b(tb[i].data, tb[i].toks);
            wait_idle_b();
        end

        // ack edge to rail change takes exactly two synchronizer edges
        @(negedge clk);
        fb_en = 1'b1;
        fb = 1'b0;
        qb.push_back(4'b1000); qb.push_back(4'b0000);
        qb.push_back(4'b0010); qb.push_back(4'b0000);
        sd_b = 4'b0111;
        sv_b = 1'b1;
        @(posedge clk);
        #1 sv_b = 1'b0;
        chk("b_lat_first_token", 32'(out_b), 32'h8);
        @(negedge clk) fb = 1'b1;
        @(posedge clk); #1 chk("b_lat_hi_k", 32'(out_b), 32'h8);
        @(posedge clk); #1 chk("b_lat_hi_k1", 32'(out_b), 32'h8);
        @(posedge clk); #1 chk("b_lat_hi_k2", 32'(out_b), 0);
        @(negedge clk) fb = 1'b0;
        @(posedge clk); #1 chk("b_lat_lo_k", 32'(out_b), 0);
        @(posedge clk); #1 chk("b_lat_lo_k1", 32'(out_b), 0);
        @(posedge clk); #1 chk("b_lat_lo_k2", 32'(out_b), 32'h2);
        @(negedge clk) fb = 1'b1;
        repeat (4) @(negedge clk);
        fb = 1'b0;
        wait_idle_b();
        fb_en = 1'b0;

        // back-to-back words with s_valid held high; data change mid-word is ignored
        @(negedge clk);
        push_a(8'b10_10_10_10);
        sd_a = 4'hF;
        sv_a = 1'b1;
        @(posedge clk);
        #1 sd_a = 4'h0;
        push_a(8'b01_01_01_01);
        n = 0;
        while (!sr_a && n < 300) begin @(negedge clk); n++; end
        chk("a_b2b_ready", 32'(sr_a), 1);
        chk("a_b2b_first_done", 32'(qa.size()), 8);
        chk("a_b2b_spacer", 32'(out_a), 0);
        @(posedge clk);
        #1 sv_a = 1'b0;
        chk("a_b2b_second_busy", 32'(busy_a), 1);
        chk("a_b2b_second_tok", 32'(out_a), 1);
        wait_idle_a();

        // ack never rises: error after 8 cycles waiting in DATA, sticky until reset
        @(negedge clk);
        fa_en = 1'b1;
        fa = 1'b0;
        qa.push_back(2'b01); qa.push_back(2'b00);
        sd_a = 4'b1010;
        sv_a = 1'b1;
        @(posedge clk);
        #1 sv_a = 1'b0;
        for (int i = 1; i < 8; i++) begin
            @(posedge clk); #1;
            chk("a_to_no_err_early", 32'(err_a), 0);
            chk("a_to_token_held", 32'(out_a), 1);
        end
        @(posedge clk); #1;
        chk("a_to_err", 32'(err_a), 1);
        chk("a_to_out", 32'(out_a), 0);
        chk("a_to_ready", 32'(sr_a), 0);
        chk("a_to_busy", 32'(busy_a), 1);
        fa = 1'b1;
        sv_a = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("a_to_err_sticky", 32'(err_a), 1);
        chk("a_to_ready_sticky", 32'(sr_a), 0);
        chk("a_to_out_sticky", 32'(out_a), 0);
        sv_a = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("a_to_rst_err", 32'(err_a), 0);
        chk("a_to_rst_busy", 32'(busy_a), 0);
        @(negedge clk);
        rst = 1'b0;
        fa_en = 1'b0;
        fa = 1'b0;
        chk("a_to_queue", 32'(qa.size()), 0);
        repeat (8) @(negedge clk);
        chk("a_to_rst_ready", 32'(sr_a), 1);

        // asynchronous reset mid-word drops the rails without a clock edge
        sd_a = 4'b1010;
        sv_a = 1'b1;
        @(posedge clk);
        #1 sv_a = 1'b0;
        chk("a_ar_token", 32'(out_a), 1);
        mon_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("a_ar_out", 32'(out_a), 0);
        chk("a_ar_busy", 32'(busy_a), 0);
        chk("a_ar_err", 32'(err_a), 0);
        #1 rst = 1'b0;
        qa.delete();
        repeat (10) @(negedge clk);
        mon_en = 1'b1;
        chk("a_ar_ready", 32'(sr_a), 1);
        send_a(4'b0110, 8'b01_10_10_01);
        chk("a_ar_restart_sym0", 32'(out_a), 1);
        wait_idle_a();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
